alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
Execute-stage sequencer for the 8-bit ALU. It accepts decoded instructions over a valid/ready handshake and fetches the register operand from data memory with one-cycle read latency. It drives the ALU and commits the ALU's write/flag strobes to the accumulator, Z/C flags and data memory. It also squashes the instruction after a taken skip and shadows the Z/C flags across interrupts.

Parameters:
ADDR_WIDTH, 8, data-memory address width; register address = operand[ADDR_WIDTH-1:0]
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
instr_valid  in  1  decoded instruction present
instr_ready  out  1  controller accepts instruction this cycle
instr_opcode  in  4  opcode
instr_selector  in  3  selector field
instr_direction  in  1  direction bit
instr_operand  in  8  immediate or register address
mem_re  out  1  data-memory read strobe
mem_raddr  out  ADDR_WIDTH  read address
mem_rdata  in  8  read data, valid cycle after mem_re
mem_we  out  1  data-memory write strobe
mem_waddr  out  ADDR_WIDTH  write address
mem_wdata  out  8  write data
alu_opcode/alu_selector/alu_direction/alu_operand  out  4/3/1/8  latched instruction fields to ALU
alu_regvalue  out  8  register value to ALU
alu_accum  out  8  accumulator to ALU
alu_cin  out  1  carry in (= c_flag)
alu_result  in  8  ALU result
alu_accum_write, alu_reg_write, alu_z_write, alu_zout, alu_c_write, alu_cout, alu_retint, alu_skip  in  1 each  ALU strobes
int_take  in  1  single-cycle pulse: interrupt vector taken
accum  out  8  accumulator register
z_flag, c_flag  out  1 each  status flags
int_active  out  1  inside interrupt handler
retint_pulse  out  1  one-cycle pulse when RETINT commits
retired  out  CNT_WIDTH  executed (non-squashed) instruction count

Behaviour:
- Reset (async, reset_n=0): state IDLE; accum, z_flag, c_flag, shadow Z/C, int_active, retired = 0. retint_pulse, mem_re and mem_we = 0. Latched instruction = 0.
- States: IDLE, READ, EXEC, SQUASH. A handshake occurs when instr_valid && instr_ready.
- instr_ready = 1 in IDLE, in EXEC when alu_skip=0, and in SQUASH. It is 0 in READ, and 0 in EXEC when alu_skip=1.
- On a handshake, the instruction fields are latched. Next state is EXEC if opcode[3:2]==01 (immediate/return; no memory operand), otherwise READ.
- READ: mem_re=1, mem_raddr=latched operand. Next state is always EXEC.
- EXEC: alu_* fields are driven from the latch. alu_regvalue = mem_rdata when the previous state was READ, else 0. Commits at the end of the cycle:
  - alu_accum_write: accum<=alu_result.
  - alu_reg_write: mem_we=1 (combinational in EXEC), mem_waddr=latched operand, mem_wdata=alu_result.
  - alu_z_write: z_flag<=alu_zout.
  - alu_c_write: c_flag<=alu_cout.
  - retired increments by 1 and wraps modulo 2^CNT_WIDTH.
- EXEC next state:
  - alu_skip=1: SQUASH.
  - else handshake: READ/EXEC per the rule above (back-to-back issue). Latency is 1 cycle accept-to-EXEC for immediates, 2 cycles for register ops.
  - else: IDLE.
- SQUASH: the next handshaken instruction is discarded. There are no ALU commits, retired does not increment, and next state is IDLE. If no instr_valid arrives, SQUASH is held indefinitely.
- RETINT (alu_retint=1 in EXEC): z_flag/c_flag <= shadow values, overriding any same-cycle z/c write. int_active<=0 and retint_pulse=1 for that cycle. If int_active=0, the flags are still restored from the shadow.
- int_take: shadow <= current-cycle post-commit Z/C (the same-cycle EXEC write is included) and int_active<=1. int_take in the same cycle as a committing RETINT: the restore wins for the flags, and int_active ends at 1 with the shadow taking the restored values.
- Strobes outside EXEC are ignored; mem_we is never asserted outside EXEC.
- Reset mid-instruction: the instruction is abandoned with no write.

Test Plan:
- Reset, then an immediate add (opcode 0110, selector 000, direction 0, operand 0x05) with accum=0 and the ALU returning result 0x05, accum_write=1 -> accum=0x05 one cycle after EXEC, retired=1, mem_re never asserted.
- Register op, opcode 0010, operand 0x12, mem_rdata=0xA0 the cycle after mem_re -> mem_re/mem_raddr=0x12 in READ, alu_regvalue=0xA0 in EXEC. With reg_write=1 and result 0xA1: mem_we=1, mem_waddr=0x12, mem_wdata=0xA1 in EXEC.
- Skip: EXEC with alu_skip=1 followed by an instruction whose ALU strobes are accum_write=1 -> instr_ready=0 that EXEC cycle, the following instruction is accepted but accum is unchanged and retired is not incremented.
- Back-to-back immediates with instr_valid held high -> one retirement per cycle, instr_ready continuously 1.
- Interrupt: set z=1 and c=1, pulse int_take, then an instruction clears both flags, then RETINT -> z_flag=1, c_flag=1, int_active=0, retint_pulse high for exactly 1 cycle.
- Assert reset_n=0 during READ -> no mem_we, all outputs at their reset values immediately.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: accepts decoded instructions, fetches register operands, commits ALU strobes.
// Latency: accept-to-EXEC 1 cycle (immediate) / 2 cycles (register); instr_ready low in READ and on a skip.
module alu_exec_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            instr_opcode,
  input  logic [2:0]            instr_selector,
  input  logic                  instr_direction,
  input  logic [7:0]            instr_operand,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]            mem_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_wdata,
  output logic [3:0]            alu_opcode,
  output logic [2:0]            alu_selector,
  output logic                  alu_direction,
  output logic [7:0]            alu_operand,
  output logic [7:0]            alu_regvalue,
  output logic [7:0]            alu_accum,
  output logic                  alu_cin,
  input  logic [7:0]            alu_result,
  input  logic                  alu_accum_write,
  input  logic                  alu_reg_write,
  input  logic                  alu_z_write,
  input  logic                  alu_zout,
  input  logic                  alu_c_write,
  input  logic                  alu_cout,
  input  logic                  alu_retint,
  input  logic                  alu_skip,
  input  logic                  int_take,
  output logic [7:0]            accum,
  output logic                  z_flag,
  output logic                  c_flag,
  output logic                  int_active,
  output logic                  retint_pulse,
  output logic [CNT_WIDTH-1:0]  retired
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_SQUASH} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic                   was_read_q, was_read_d;
  logic [3:0]             opcode_q, opcode_d;
  logic [2:0]             selector_q, selector_d;
  logic                   direction_q, direction_d;
  logic [7:0]             operand_q, operand_d;
  logic [7:0]             accum_q, accum_d;
  logic                   z_q, z_d;
  logic                   c_q, c_d;
  logic                   sz_q, sz_d;
  logic                   sc_q, sc_d;
  logic                   int_active_q, int_active_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;

  logic accept;
  logic issue;
  logic new_is_imm;
  logic exec;

  always_comb begin
    instr_ready = 1'b0;
    case (state_q)
      S_IDLE, S_SQUASH: instr_ready = 1'b1;
      S_EXEC:           instr_ready = ~alu_skip;
      default:          instr_ready = 1'b0;
    endcase
  end

  assign accept     = instr_valid & instr_ready;
  // A handshake in SQUASH is the discarded instruction; it never reaches the latch.
  assign issue      = accept & (state_q != S_SQUASH);
  assign new_is_imm = (instr_opcode[3:2] == 2'b01);
  assign exec       = (state_q == S_EXEC);

  always_comb begin
    state_d      = state_q;
    was_read_d   = (state_q == S_READ);
    opcode_d     = opcode_q;
    selector_d   = selector_q;
    direction_d  = direction_q;
    operand_d    = operand_q;
    accum_d      = accum_q;
    z_d          = z_q;
    c_d          = c_q;
    sz_d         = sz_q;
    sc_d         = sc_q;
    int_active_d = int_active_q;
    retired_d    = retired_q;
    mem_we       = 1'b0;
    retint_pulse = 1'b0;

    if (issue) begin
      opcode_d    = instr_opcode;
      selector_d  = instr_selector;
      direction_d = instr_direction;
      operand_d   = instr_operand;
    end

    case (state_q)
      S_IDLE: begin
        if (issue) state_d = new_is_imm ? S_EXEC : S_READ;
      end
      S_READ: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (alu_accum_write) accum_d = alu_result;
        if (alu_reg_write)   mem_we  = 1'b1;
        if (alu_z_write)     z_d     = alu_zout;
        if (alu_c_write)     c_d     = alu_cout;
        // Returning from an interrupt restores the shadowed flags over any same-cycle flag write.
        if (alu_retint) begin
          z_d          = sz_q;
          c_d          = sc_q;
          int_active_d = 1'b0;
          retint_pulse = 1'b1;
        end
        retired_d = retired_q + CNT_ONE;
        if (alu_skip)   state_d = S_SQUASH;
        else if (issue) state_d = new_is_imm ? S_EXEC : S_READ;
        else            state_d = S_IDLE;
      end
      S_SQUASH: begin
        if (accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Shadow captures post-commit flags, so a coincident RETINT hands its restored values over.
    if (int_take) begin
      sz_d         = z_d;
      sc_d         = c_d;
      int_active_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      was_read_q   <= 1'b0;
      opcode_q     <= 4'h0;
      selector_q   <= 3'h0;
      direction_q  <= 1'b0;
      operand_q    <= 8'h00;
      accum_q      <= 8'h00;
      z_q          <= 1'b0;
      c_q          <= 1'b0;
      sz_q         <= 1'b0;
      sc_q         <= 1'b0;
      int_active_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      was_read_q   <= was_read_d;
      opcode_q     <= opcode_d;
      selector_q   <= selector_d;
      direction_q  <= direction_d;
      operand_q    <= operand_d;
      accum_q      <= accum_d;
      z_q          <= z_d;
      c_q          <= c_d;
      sz_q         <= sz_d;
      sc_q         <= sc_d;
      int_active_q <= int_active_d;
      retired_q    <= retired_d;
    end
  end

  assign mem_re        = (state_q == S_READ);
  assign mem_raddr     = operand_q[ADDR_WIDTH-1:0];
  assign mem_waddr     = operand_q[ADDR_WIDTH-1:0];
  assign mem_wdata     = alu_result;

  assign alu_opcode    = opcode_q;
  assign alu_selector  = selector_q;
  assign alu_direction = direction_q;
  assign alu_operand   = operand_q;
  assign alu_regvalue  = (exec && was_read_q) ? mem_rdata : 8'h00;
  assign alu_accum     = accum_q;
  assign alu_cin       = c_q;

  assign accum         = accum_q;
  assign z_flag        = z_q;
  assign c_flag        = c_q;
  assign int_active    = int_active_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: toy ALU and data memory around the DUT, ISA-level model feeding a scoreboard.
module tb_alu_exec_ctrl;
  localparam int AW = 8;
  localparam int CW = 6;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ST    = 4'h1;
  localparam logic [3:0] OP_INC   = 4'h2;
  localparam logic [3:0] OP_LDI   = 4'h4;
  localparam logic [3:0] OP_RETI  = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_SKIPZ = 4'h7;

  logic clk, reset_n;
  logic instr_valid, instr_ready, instr_direction;
  logic [3:0] instr_opcode;
  logic [2:0] instr_selector;
  logic [7:0] instr_operand;
  logic mem_re, mem_we;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [7:0] mem_rdata, mem_wdata;
  logic [3:0] alu_opcode;
  logic [2:0] alu_selector;
  logic alu_direction, alu_cin;
  logic [7:0] alu_operand, alu_regvalue, alu_accum, alu_result;
  logic alu_accum_write, alu_reg_write, alu_z_write, alu_zout, alu_c_write, alu_cout;
  logic alu_retint, alu_skip, int_take;
  logic [7:0] accum;
  logic z_flag, c_flag, int_active, retint_pulse;
  logic [CW-1:0] retired;

  alu_exec_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_selector(instr_selector),
    .instr_direction(instr_direction), .instr_operand(instr_operand),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .alu_opcode(alu_opcode), .alu_selector(alu_selector), .alu_direction(alu_direction),
    .alu_operand(alu_operand), .alu_regvalue(alu_regvalue), .alu_accum(alu_accum),
    .alu_cin(alu_cin), .alu_result(alu_result),
    .alu_accum_write(alu_accum_write), .alu_reg_write(alu_reg_write),
    .alu_z_write(alu_z_write), .alu_zout(alu_zout),
    .alu_c_write(alu_c_write), .alu_cout(alu_cout),
    .alu_retint(alu_retint), .alu_skip(alu_skip), .int_take(int_take),
    .accum(accum), .z_flag(z_flag), .c_flag(c_flag), .int_active(int_active),
    .retint_pulse(retint_pulse), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy ALU. ADDI folds in regvalue so a non-zero regvalue on an immediate corrupts the sum.
  logic [8:0] stub_sum;
  always_comb begin
    stub_sum = 9'h000;
    alu_result = 8'h00;
    alu_accum_write = 1'b0; alu_reg_write = 1'b0;
    alu_z_write = 1'b0; alu_zout = 1'b0;
    alu_c_write = 1'b0; alu_cout = 1'b0;
    alu_retint = 1'b0; alu_skip = 1'b0;
    case (alu_opcode)
      OP_LDI: begin
        alu_result = alu_operand ^ {5'b0, alu_selector};
        alu_accum_write = 1'b1; alu_z_write = 1'b1;
      end
      OP_RETI: begin
        alu_retint = 1'b1; alu_z_write = 1'b1; alu_c_write = 1'b1;
      end
      OP_ADDI: begin
        stub_sum = {1'b0, alu_accum} + {1'b0, alu_operand} + {1'b0, alu_regvalue}
                 + {8'b0, alu_direction & alu_cin};
        alu_result = stub_sum[7:0];
        alu_accum_write = 1'b1; alu_z_write = 1'b1; alu_c_write = 1'b1; alu_cout = stub_sum[8];
      end
      OP_SKIPZ: alu_skip = z_flag;
      OP_ADD: begin
        stub_sum = {1'b0, alu_accum} + {1'b0, alu_regvalue} + {8'b0, alu_direction & alu_cin};
        alu_result = stub_sum[7:0];
        alu_accum_write = 1'b1; alu_z_write = 1'b1; alu_c_write = 1'b1; alu_cout = stub_sum[8];
      end
      OP_ST: begin
        alu_result = alu_accum; alu_reg_write = 1'b1;
      end
      OP_INC: begin
        stub_sum = {1'b0, alu_regvalue} + 9'h001;
        alu_result = stub_sum[7:0];
        alu_reg_write = 1'b1; alu_z_write = 1'b1; alu_c_write = 1'b1; alu_cout = stub_sum[8];
      end
      4'h3: alu_skip = alu_regvalue[0];
      default: begin
        alu_result = alu_regvalue ^ {5'b0, alu_selector};
        alu_accum_write = 1'b1; alu_z_write = 1'b1;
        alu_c_write = alu_direction; alu_cout = alu_regvalue[7];
      end
    endcase
    if (alu_opcode != OP_RETI) alu_zout = (alu_result == 8'h00);
  end

  // Data memory: one-cycle read latency, junk on the read port when nothing was read.
  logic [7:0] env_mem [256];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 8'(i) ^ 8'h5A;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_we) env_mem[mem_waddr] <= mem_wdata;
      mem_rdata <= mem_re ? env_mem[mem_raddr] : 8'($urandom);
    end
  end

  typedef struct packed {
    logic [7:0]    acc;
    logic          z;
    logic          c;
    logic          ia;
    logic [CW-1:0] ret;
    logic          rti;
  } snap_t;

  snap_t      exp_st_q[$];
  logic [7:0] exp_rd_q[$];
  logic [15:0] exp_wr_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state updated instruction by instruction.
  logic [7:0]    m_acc, m_mem [256];
  logic          m_z, m_c, m_sz, m_sc, m_ia, m_squash;
  logic [CW-1:0] m_ret;

  task automatic model_reset();
    m_acc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_sz = 1'b0; m_sc = 1'b0;
    m_ia = 1'b0; m_squash = 1'b0; m_ret = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h5A;
    exp_st_q.delete(); exp_rd_q.delete(); exp_wr_q.delete();
  endtask

  task automatic model_take();
    m_sz = m_z; m_sc = m_c; m_ia = 1'b1;
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [2:0] sel, input logic dir,
                            input logic [7:0] opnd, input logic take);
    logic [7:0] rv;
    logic [8:0] s;
    logic       rti;
    snap_t      sn;
    rv = 8'h00; s = 9'h000; rti = 1'b0;
    if (m_squash) begin
      m_squash = 1'b0;
      if (take) model_take();
    end else begin
      if (op[3:2] != 2'b01) begin
        rv = m_mem[opnd];
        exp_rd_q.push_back(opnd);
      end
      case (op)
        OP_LDI:   begin m_acc = opnd ^ {5'b0, sel}; m_z = (m_acc == 8'h00); end
        OP_RETI:  begin m_z = m_sz; m_c = m_sc; m_ia = 1'b0; rti = 1'b1; end
        OP_ADDI:  begin s = 9'(m_acc) + 9'(opnd) + 9'(dir && m_c);
                        m_acc = s[7:0]; m_z = (s[7:0] == 8'h00); m_c = s[8]; end
        OP_SKIPZ: m_squash = m_z;
        OP_ADD:   begin s = 9'(m_acc) + 9'(rv) + 9'(dir && m_c);
                        m_acc = s[7:0]; m_z = (s[7:0] == 8'h00); m_c = s[8]; end
        OP_ST:    begin m_mem[opnd] = m_acc; exp_wr_q.push_back({opnd, m_acc}); end
        OP_INC:   begin s = 9'(rv) + 9'd1; m_mem[opnd] = s[7:0];
                        exp_wr_q.push_back({opnd, s[7:0]});
                        m_z = (s[7:0] == 8'h00); m_c = s[8]; end
        4'h3:     m_squash = rv[0];
        default:  begin m_acc = rv ^ {5'b0, sel}; m_z = (m_acc == 8'h00);
                        if (dir) m_c = rv[7]; end
      endcase
      m_ret = m_ret + 1'b1;
      if (take) model_take();
      sn.acc = m_acc; sn.z = m_z; sn.c = m_c; sn.ia = m_ia; sn.ret = m_ret; sn.rti = rti;
      exp_st_q.push_back(sn);
    end
  endtask

  // Monitor: every retirement, memory read and memory write is matched against the queues.
  logic [CW-1:0] last_ret;
  logic          rti_seen;
  always @(negedge clk) begin
    snap_t sn;
    if (!reset_n) begin
      last_ret = '0;
      rti_seen = 1'b0;
    end else begin
      if (retired != last_ret) begin
        last_ret = retired;
        if (exp_st_q.size() == 0) begin
          check("unexpected_retire", 32'(retired), 32'(m_ret));
        end else begin
          sn = exp_st_q.pop_front();
          check("retired", 32'(retired), 32'(sn.ret));
          check("accum", 32'(accum), 32'(sn.acc));
          check("z_flag", 32'(z_flag), 32'(sn.z));
          check("c_flag", 32'(c_flag), 32'(sn.c));
          check("int_active", 32'(int_active), 32'(sn.ia));
          check("retint_pulse", 32'(rti_seen), 32'(sn.rti));
        end
        rti_seen = 1'b0;
      end
      if (retint_pulse) begin
        if (rti_seen) check("retint_width", 32'd2, 32'd1);
        rti_seen = 1'b1;
      end
      if (mem_re) begin
        if (exp_rd_q.size() == 0) check("unexpected_mem_re", 32'(mem_raddr), 32'hFFFF_FFFF);
        else check("mem_raddr", 32'(mem_raddr), 32'(exp_rd_q.pop_front()));
      end
      if (mem_we) begin
        if (exp_wr_q.size() == 0) check("unexpected_mem_we", 32'({mem_waddr, mem_wdata}), 32'hFFFF_FFFF);
        else check("mem_write", 32'({mem_waddr, mem_wdata}), 32'(exp_wr_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [2:0] sel, input logic dir,
                       input logic [7:0] opnd, input logic take, output int stalls);
    bit done;
    model_exec(op, sel, dir, opnd, take);
    instr_valid = 1'b1; instr_opcode = op; instr_selector = sel;
    instr_direction = dir; instr_operand = opnd;
    stalls = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (instr_ready) begin
        done = 1'b1;
      end else begin
        stalls++;
        @(posedge clk); #1;
        int_take = 1'b0;
        if (stalls > 20) begin
          check("handshake_timeout", 32'(stalls), 32'd20);
          instr_valid = 1'b0;
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    int_take = take;
  endtask

  task automatic idle(input int n, input logic take);
    instr_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; int_take = 1'b0; end
    if (take) begin
      model_take();
      int_take = 1'b1;
      @(posedge clk); #1;
      int_take = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_accum"}, 32'(accum), 32'd0);
    check({tag, "_z"}, 32'(z_flag), 32'd0);
    check({tag, "_c"}, 32'(c_flag), 32'd0);
    check({tag, "_int_active"}, 32'(int_active), 32'd0);
    check({tag, "_retired"}, 32'(retired), 32'd0);
    check({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_retint_pulse"}, 32'(retint_pulse), 32'd0);
    check({tag, "_instr_ready"}, 32'(instr_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [3:0] op;
    logic [7:0] opnd;
    logic imm, tk;

    reset_n = 1'b0; instr_valid = 1'b0; instr_opcode = 4'h0; instr_selector = 3'h0;
    instr_direction = 1'b0; instr_operand = 8'h00; int_take = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    issue(OP_ADDI, 3'd0, 1'b0, 8'h05, 1'b0, st);

    issue(OP_LDI, 3'd0, 1'b0, 8'hA0, 1'b0, st);
    issue(OP_ST, 3'd0, 1'b0, 8'h12, 1'b0, st);
    issue(OP_INC, 3'd0, 1'b0, 8'h12, 1'b0, st);
    idle(2, 1'b0);

    issue(OP_LDI, 3'd0, 1'b0, 8'h00, 1'b0, st);
    issue(OP_SKIPZ, 3'd0, 1'b0, 8'h00, 1'b0, st);
    issue(OP_ADDI, 3'd0, 1'b0, 8'h07, 1'b0, st);
    check("skip_stall_cycles", 32'(st), 32'd1);
    issue(OP_LDI, 3'd0, 1'b0, 8'h33, 1'b0, st);
    check("after_squash_stall", 32'(st), 32'd0);

    for (int i = 0; i < 8; i++) begin
      issue(OP_ADDI, 3'd0, 1'b0, 8'(i + 1), 1'b0, st);
      check("b2b_stall", 32'(st), 32'd0);
    end

    issue(OP_LDI, 3'd0, 1'b0, 8'h01, 1'b0, st);
    issue(OP_ADDI, 3'd0, 1'b0, 8'hFF, 1'b0, st);
    idle(3, 1'b1);
    issue(OP_ADDI, 3'd0, 1'b0, 8'h01, 1'b0, st);
    issue(OP_RETI, 3'd0, 1'b0, 8'h00, 1'b0, st);
    issue(OP_ADDI, 3'd0, 1'b0, 8'h10, 1'b1, st);
    issue(OP_RETI, 3'd0, 1'b0, 8'h00, 1'b1, st);
    idle(3, 1'b0);

    for (int i = 0; i < 400; i++) begin
      op   = 4'($urandom_range(0, 15));
      imm  = (op[3:2] == 2'b01);
      opnd = imm ? 8'($urandom) : 8'($urandom_range(0, 7));
      issue(op, 3'($urandom), 1'($urandom), opnd, imm && ($urandom_range(0, 5) == 0), st);
      if ($urandom_range(0, 4) == 0) begin
        tk = 1'($urandom);
        idle(tk ? 3 : 1 + $urandom_range(0, 2), tk);
      end
    end
    if (m_squash) issue(OP_LDI, 3'd0, 1'b0, 8'h00, 1'b0, st);
    idle(6, 1'b0);
    check("leftover_retires", 32'(exp_st_q.size()), 32'd0);
    check("leftover_reads", 32'(exp_rd_q.size()), 32'd0);
    check("leftover_writes", 32'(exp_wr_q.size()), 32'd0);

    // Reset lands while the register read is in flight; the write must never appear.
    exp_rd_q.push_back(8'h03);
    instr_valid = 1'b1; instr_opcode = OP_INC; instr_selector = 3'd0;
    instr_direction = 1'b0; instr_operand = 8'h03;
    @(negedge clk);
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midread");
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(4, 1'b0);
    check("post_reset_retired", 32'(retired), 32'd0);
    check("post_reset_reads", 32'(exp_rd_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
